// File: rtl/interrupt_unit_pkg.sv
// Shared constants for the interrupt unit: vector addresses, FSM encoding and
// the source-id width helper (NMI uses id = IRQ_LINES).
package interrupt_unit_pkg;

    localparam int          IRQ_LINES_DEF = 8;
    localparam logic [15:0] VEC_RST_DEF   = 16'hFFFE;
    localparam logic [15:0] VEC_NMI_DEF   = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ0_DEF  = 16'hFFFA;

    typedef enum logic [1:0] {
        ST_RSTH = 2'd0,
        ST_IDLE = 2'd1,
        ST_REQ  = 2'd2,
        ST_ACKD = 2'd3
    } state_e;

    // One extra code point above the IRQ lines is reserved for the NMI id.
    function automatic int id_width(input int lines);
        return $clog2(lines + 1);
    endfunction

endpackage

// File: rtl/interrupt_unit_prio.sv
// Combinational fixed-priority arbiter: NMI first, then the lowest-index
// maskable line, the latter only while GIE is set.
module irq_priority_encoder
    import interrupt_unit_pkg::*;
#(
    parameter int          IRQ_LINES = IRQ_LINES_DEF,
    parameter logic [15:0] VEC_NMI   = VEC_NMI_DEF,
    parameter logic [15:0] VEC_IRQ0  = VEC_IRQ0_DEF,
    parameter int          ID_W      = id_width(IRQ_LINES)
) (
    input  logic [IRQ_LINES-1:0] pend_i,
    input  logic                 nmi_pend_i,
    input  logic                 gie_i,
    output logic                 valid_o,
    output logic [ID_W-1:0]      id_o,
    output logic [15:0]          vec_o
);

    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        vec_o   = VEC_IRQ0;
        // Scan downward so the lowest pending index is the last one written.
        if (gie_i) begin
            for (int k = IRQ_LINES - 1; k >= 0; k--) begin
                if (pend_i[k]) begin
                    valid_o = 1'b1;
                    id_o    = ID_W'(k);
                    vec_o   = VEC_IRQ0 - 16'(2 * k);
                end
            end
        end
        if (nmi_pend_i) begin
            valid_o = 1'b1;
            id_o    = ID_W'(IRQ_LINES);
            vec_o   = VEC_NMI;
        end
    end

endmodule

// File: rtl/interrupt_unit.sv
// Interrupt/reset request source for the CAR select: edge-detects NMI/IRQ,
// holds pending flags, arbitrates and retires the serviced source on INTACK.
module interrupt_unit
    import interrupt_unit_pkg::*;
#(
    parameter int          IRQ_LINES = IRQ_LINES_DEF,
    parameter logic [15:0] VEC_RST   = VEC_RST_DEF,
    parameter logic [15:0] VEC_NMI   = VEC_NMI_DEF,
    parameter logic [15:0] VEC_IRQ0  = VEC_IRQ0_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 GIE,
    input  logic                 NMI,
    input  logic [IRQ_LINES-1:0] IRQ,
    input  logic                 INTACK,
    output logic                 RSTREQ,
    output logic                 INTREQ,
    output logic [15:0]          INTVEC,
    output logic [IRQ_LINES-1:0] IRQACK
);

    localparam int              ID_W   = id_width(IRQ_LINES);
    localparam logic [ID_W-1:0] NMI_ID = ID_W'(IRQ_LINES);

    state_e                state_q, state_d;
    logic                  rsth_first_q, rsth_first_d;
    logic                  nmi_q, nmi_pend_q, nmi_pend_d, nmi_clr;
    logic [IRQ_LINES-1:0]  irq_q, pend_q, pend_d, clr;
    logic [ID_W-1:0]       id_q, id_d;
    logic [15:0]           vec_q, vec_d;
    logic                  intreq_q, intreq_d, rstreq_q, rstreq_d;
    logic [IRQ_LINES-1:0]  irqack_q, irqack_d;

    logic                  win_valid;
    logic [ID_W-1:0]       win_id;
    logic [15:0]           win_vec;

    irq_priority_encoder #(
        .IRQ_LINES (IRQ_LINES),
        .VEC_NMI   (VEC_NMI),
        .VEC_IRQ0  (VEC_IRQ0),
        .ID_W      (ID_W)
    ) u_prio (
        .pend_i     (pend_q),
        .nmi_pend_i (nmi_pend_q),
        .gie_i      (GIE),
        .valid_o    (win_valid),
        .id_o       (win_id),
        .vec_o      (win_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RSTH;
            rsth_first_q <= 1'b1;
            nmi_q        <= 1'b0;
            irq_q        <= '0;
            nmi_pend_q   <= 1'b0;
            pend_q       <= '0;
            id_q         <= '0;
            vec_q        <= VEC_RST;
            intreq_q     <= 1'b0;
            rstreq_q     <= 1'b1;
            irqack_q     <= '0;
        end else begin
            state_q      <= state_d;
            rsth_first_q <= rsth_first_d;
            nmi_q        <= NMI;
            irq_q        <= IRQ;
            nmi_pend_q   <= nmi_pend_d;
            pend_q       <= pend_d;
            id_q         <= id_d;
            vec_q        <= vec_d;
            intreq_q     <= intreq_d;
            rstreq_q     <= rstreq_d;
            irqack_q     <= irqack_d;
        end
    end

    // RSTH is held for one extra edge after reset release.
    always_comb begin
        state_d      = state_q;
        rsth_first_d = 1'b0;
        unique case (state_q)
            ST_RSTH: if (!rsth_first_q) state_d = ST_IDLE;
            ST_IDLE: if (win_valid) state_d = ST_REQ;
            ST_REQ: begin
                if (INTACK)          state_d = ST_ACKD;
                else if (!win_valid) state_d = ST_IDLE;
            end
            ST_ACKD: state_d = ST_IDLE;
            default: state_d = ST_RSTH;
        endcase
    end

    always_comb begin
        id_d     = id_q;
        vec_d    = vec_q;
        irqack_d = '0;
        nmi_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    id_d  = win_id;
                    vec_d = win_vec;
                end
            end
            ST_REQ: begin
                if (INTACK) begin
                    if (id_q == NMI_ID) begin
                        nmi_clr = 1'b1;
                    end else begin
                        for (int k = 0; k < IRQ_LINES; k++)
                            irqack_d[k] = (id_q == ID_W'(k));
                    end
                end else if (win_valid) begin
                    id_d  = win_id;
                    vec_d = win_vec;
                end
            end
            default: ;
        endcase
        clr      = irqack_d;
        // A fresh rising edge outranks the clear from the acknowledge.
        pend_d     = (pend_q & ~clr) | (IRQ & ~irq_q);
        nmi_pend_d = (nmi_pend_q & ~nmi_clr) | (NMI & ~nmi_q);
        intreq_d   = (state_d == ST_REQ);
        rstreq_d   = (state_d == ST_RSTH);
    end

    assign RSTREQ = rstreq_q;
    assign INTREQ = intreq_q;
    assign INTVEC = vec_q;
    assign IRQACK = irqack_q;

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed + randomized bench for interrupt_unit, checked every cycle against
// a behavioural model of the request/acknowledge rules.
module tb_interrupt_unit;

    logic        clk = 1'b0;
    logic        rst, GIE, NMI, INTACK;
    logic [7:0]  IRQ;
    logic        RSTREQ, INTREQ;
    logic [15:0] INTVEC;
    logic [7:0]  IRQACK;

    int checks = 0;
    int errors = 0;

    interrupt_unit dut (
        .clk    (clk),
        .rst    (rst),
        .GIE    (GIE),
        .NMI    (NMI),
        .IRQ    (IRQ),
        .INTACK (INTACK),
        .RSTREQ (RSTREQ),
        .INTREQ (INTREQ),
        .INTVEC (INTVEC),
        .IRQACK (IRQACK)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [7:0]    m_pend, m_prev, m_ack;
    bit          m_npend, m_nprev, m_rstreq, m_first, m_req, m_blank;
    int          m_id;
    logic [15:0] m_vec;

    function automatic int winner(bit [7:0] p, bit np, bit g);
        if (np) return 8;
        if (g) for (int i = 0; i < 8; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] vec_of(int id);
        if (id == 8) return 16'hFFFC;
        return 16'hFFFA - 16'(2 * id);
    endfunction

    task automatic model_step();
        bit [7:0] rise, clrv;
        bit       nrise, nclr;
        int       w;
        if (rst) begin
            m_pend = '0; m_prev = '0; m_npend = 0; m_nprev = 0;
            m_rstreq = 1; m_first = 1; m_req = 0; m_blank = 0;
            m_vec = 16'hFFFE; m_ack = '0;
        end else begin
            rise  = IRQ & ~m_prev;
            nrise = NMI & !m_nprev;
            clrv  = '0;
            nclr  = 0;
            m_ack = '0;
            w = winner(m_pend, m_npend, GIE);
            if (m_rstreq) begin
                if (m_first) m_first = 0;
                else m_rstreq = 0;
            end else if (m_blank) begin
                m_blank = 0;
            end else if (m_req) begin
                if (INTACK) begin
                    if (m_id == 8) nclr = 1;
                    else begin
                        clrv[m_id] = 1'b1;
                        m_ack = clrv;
                    end
                    m_req = 0;
                    m_blank = 1;
                end else if (w < 0) begin
                    m_req = 0;
                end else begin
                    m_id = w;
                    m_vec = vec_of(w);
                end
            end else if (w >= 0) begin
                m_req = 1;
                m_id = w;
                m_vec = vec_of(w);
            end
            m_pend  = (m_pend & ~clrv) | rise;
            m_npend = (m_npend & !nclr) | nrise;
            m_prev  = IRQ;
            m_nprev = NMI;
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("model_rstreq", 32'(RSTREQ), 32'(m_rstreq));
        chk("model_intreq", 32'(INTREQ), 32'(m_req));
        chk("model_intvec", 32'(INTVEC), 32'(m_vec));
        chk("model_irqack", 32'(IRQACK), 32'(m_ack));
    endtask

    initial begin
        rst = 1; GIE = 0; NMI = 0; INTACK = 0; IRQ = '0;
        m_id = 0;
        // reset release
        repeat (3) cyc();
        chk("rst_rstreq", 32'(RSTREQ), 1);
        chk("rst_vec", 32'(INTVEC), 32'hFFFE);
        rst = 0;
        cyc();
        chk("rel_rstreq_hold", 32'(RSTREQ), 1);
        chk("rel_vec", 32'(INTVEC), 32'hFFFE);
        cyc();
        chk("rel_rstreq_drop", 32'(RSTREQ), 0);
        chk("rel_intreq", 32'(INTREQ), 0);

        // single IRQ on line 3
        GIE = 1; IRQ[3] = 1;
        cyc();
        chk("irq3_latency", 32'(INTREQ), 0);
        cyc();
        chk("irq3_req", 32'(INTREQ), 1);
        chk("irq3_vec", 32'(INTVEC), 32'hFFF4);
        INTACK = 1;
        cyc();
        chk("irq3_ack", 32'(IRQACK), 32'h08);
        chk("irq3_req_drop", 32'(INTREQ), 0);
        INTACK = 0;
        cyc();
        chk("irq3_ack_pulse", 32'(IRQACK), 0);
        cyc();
        chk("irq3_retired", 32'(INTREQ), 0);
        IRQ = '0;

        // line 5 preempted by NMI
        IRQ[5] = 1;
        cyc(); cyc();
        chk("irq5_vec", 32'(INTVEC), 32'hFFF0);
        NMI = 1;
        cyc();
        cyc();
        chk("nmi_preempt_vec", 32'(INTVEC), 32'hFFFC);
        chk("nmi_preempt_req", 32'(INTREQ), 1);
        INTACK = 1;
        cyc();
        chk("nmi_no_irqack", 32'(IRQACK), 0);
        INTACK = 0;
        cyc(); cyc();
        chk("irq5_rereq", 32'(INTREQ), 1);
        chk("irq5_revec", 32'(INTVEC), 32'hFFF0);
        INTACK = 1;
        cyc();
        chk("irq5_ack", 32'(IRQACK), 32'h20);
        INTACK = 0; NMI = 0; IRQ = '0;
        cyc(); cyc();

        // masking
        GIE = 0; IRQ[0] = 1;
        repeat (3) cyc();
        chk("mask_hold", 32'(INTREQ), 0);
        GIE = 1;
        cyc();
        chk("mask_release", 32'(INTREQ), 1);
        chk("mask_vec0", 32'(INTVEC), 32'hFFFA);
        GIE = 0;
        cyc();
        chk("mask_withdraw", 32'(INTREQ), 0);
        GIE = 1;
        cyc();
        chk("mask_return", 32'(INTREQ), 1);
        GIE = 0; NMI = 1;
        cyc(); cyc();
        chk("nmi_unmasked_req", 32'(INTREQ), 1);
        chk("nmi_unmasked_vec", 32'(INTVEC), 32'hFFFC);
        INTACK = 1;
        cyc();
        INTACK = 0; NMI = 0;
        cyc(); cyc();
        chk("mask_after_nmi", 32'(INTREQ), 0);
        GIE = 1;
        cyc();
        INTACK = 1;
        cyc();
        chk("irq0_ack", 32'(IRQACK), 32'h01);
        INTACK = 0; IRQ = '0;
        cyc(); cyc();

        // simultaneous set and clear on line 2
        IRQ[2] = 1;
        cyc(); cyc();
        chk("irq2_vec", 32'(INTVEC), 32'hFFF6);
        IRQ[2] = 0;
        cyc();
        IRQ[2] = 1; INTACK = 1;
        cyc();
        chk("irq2_ack", 32'(IRQACK), 32'h04);
        INTACK = 0;
        cyc();
        chk("irq2_blank", 32'(INTREQ), 0);
        cyc();
        chk("irq2_rereq", 32'(INTREQ), 1);
        INTACK = 1;
        cyc();
        INTACK = 0; IRQ = '0;
        cyc(); cyc();

        // reset in the middle of a request
        IRQ = 8'b0100_1010;
        cyc(); cyc();
        chk("mid_req", 32'(INTREQ), 1);
        chk("mid_vec", 32'(INTVEC), 32'hFFF8);
        rst = 1;
        cyc();
        chk("mid_rst_intreq", 32'(INTREQ), 0);
        chk("mid_rst_rstreq", 32'(RSTREQ), 1);
        IRQ = '0;
        cyc();
        rst = 0;
        repeat (6) cyc();
        chk("mid_rst_idle", 32'(INTREQ), 0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            rst    = ($urandom_range(0, 199) == 0);
            GIE    = ($urandom_range(0, 9) != 0);
            INTACK = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) NMI = ~NMI;
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 7) == 0) IRQ[i] = ~IRQ[i];
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
